mips_multicycle_control: RTL and testbench

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

---
 rtl/mips_multicycle_control.sv | 219 +++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: a Moore FSM that sequences fetch, decode,
// memory, execute and write-back steps. It also holds the instruction
// register. All control outputs are registered, and each one always matches
// the decode of the current state.
module mips_multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_data,
  output logic [31:0] ir,
  output logic [15:0] imm16,
  output logic [3:0]  state,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        illegal,
  output logic        instr_done
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEMADDR   = 4'd2,
    MEMREAD   = 4'd3,
    MEMWB     = 4'd4,
    MEMWRITE  = 4'd5,
    EXEC      = 4'd6,
    RCOMPLETE = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EX   = 4'd10,
    ADDI_WB   = 4'd11,
    TRAP      = 4'd12
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Bit positions inside the packed control word.
  localparam int B_PC_WRITE      = 17;
  localparam int B_PC_WRITE_COND = 16;
  localparam int B_I_OR_D        = 15;
  localparam int B_MEM_READ      = 14;
  localparam int B_MEM_WRITE     = 13;
  localparam int B_IR_WRITE      = 12;
  localparam int B_MEM_TO_REG    = 11;
  localparam int B_REG_DST       = 10;
  localparam int B_REG_WRITE     = 9;
  localparam int B_ALU_SRC_A     = 8;
  localparam int B_ILLEGAL       = 1;
  localparam int B_INSTR_DONE    = 0;
  // alu_src_b = [7:6], alu_op = [5:4], pc_source = [3:2]

  stateT       stateR;
  stateT       nextStateS;
  logic [17:0] ctlR;
  logic [31:0] irR;
  logic [5:0]  opcodeS;

  // Moore decode of one state into the packed control word.
  function automatic logic [17:0] decodeCtl(input stateT s);
    logic [17:0] c;
    c = 18'd0;
    case (s)
      FETCH: begin
        c[B_MEM_READ] = 1'b1;
        c[B_IR_WRITE] = 1'b1;
        c[B_PC_WRITE] = 1'b1;
        c[7:6]        = 2'b01;
      end
      DECODE: begin
        c[7:6] = 2'b11;
      end
      MEMADDR: begin
        c[B_ALU_SRC_A] = 1'b1;
        c[7:6]         = 2'b10;
      end
      MEMREAD: begin
        c[B_MEM_READ] = 1'b1;
        c[B_I_OR_D]   = 1'b1;
      end
      MEMWB: begin
        c[B_REG_WRITE]  = 1'b1;
        c[B_MEM_TO_REG] = 1'b1;
        c[B_INSTR_DONE] = 1'b1;
      end
      MEMWRITE: begin
        c[B_MEM_WRITE]  = 1'b1;
        c[B_I_OR_D]     = 1'b1;
        c[B_INSTR_DONE] = 1'b1;
      end
      EXEC: begin
        c[B_ALU_SRC_A] = 1'b1;
        c[5:4]         = 2'b10;
      end
      RCOMPLETE: begin
        c[B_REG_DST]    = 1'b1;
        c[B_REG_WRITE]  = 1'b1;
        c[B_INSTR_DONE] = 1'b1;
      end
      BRANCH: begin
        c[B_ALU_SRC_A]     = 1'b1;
        c[5:4]             = 2'b01;
        c[B_PC_WRITE_COND] = 1'b1;
        c[3:2]             = 2'b01;
        c[B_INSTR_DONE]    = 1'b1;
      end
      JUMP: begin
        c[B_PC_WRITE]   = 1'b1;
        c[3:2]          = 2'b10;
        c[B_INSTR_DONE] = 1'b1;
      end
      ADDI_EX: begin
        c[B_ALU_SRC_A] = 1'b1;
        c[7:6]         = 2'b10;
      end
      ADDI_WB: begin
        c[B_REG_WRITE]  = 1'b1;
        c[B_INSTR_DONE] = 1'b1;
      end
      TRAP: begin
        c[B_ILLEGAL] = 1'b1;
      end
      default: begin
        c = 18'd0;
      end
    endcase
    return c;
  endfunction

  assign opcodeS = irR[31:26];

  // Next-state selection; the funct field is deliberately not examined.
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      FETCH: nextStateS = DECODE;
      DECODE: begin
        case (opcodeS)
          OP_RTYPE: nextStateS = EXEC;
          OP_LW:    nextStateS = MEMADDR;
          OP_SW:    nextStateS = MEMADDR;
          OP_BEQ:   nextStateS = BRANCH;
          OP_J:     nextStateS = JUMP;
          OP_ADDI:  nextStateS = ADDI_EX;
          default:  nextStateS = TRAP;
        endcase
      end
      MEMADDR: begin
        if (opcodeS == OP_SW) begin
          nextStateS = MEMWRITE;
        end else begin
          nextStateS = MEMREAD;
        end
      end
      MEMREAD:   nextStateS = MEMWB;
      EXEC:      nextStateS = RCOMPLETE;
      ADDI_EX:   nextStateS = ADDI_WB;
      MEMWB:     nextStateS = FETCH;
      MEMWRITE:  nextStateS = FETCH;
      RCOMPLETE: nextStateS = FETCH;
      BRANCH:    nextStateS = FETCH;
      JUMP:      nextStateS = FETCH;
      ADDI_WB:   nextStateS = FETCH;
      TRAP:      nextStateS = TRAP;
      default:   nextStateS = TRAP;
    endcase
  end

  // State, registered control outputs (pre-decoded from the next state) and IR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateR <= FETCH;
      ctlR   <= decodeCtl(FETCH);
      irR    <= 32'd0;
    end else begin
      stateR <= nextStateS;
      ctlR   <= decodeCtl(nextStateS);
      if (ctlR[B_IR_WRITE]) begin
        irR <= mem_data;
      end else begin
        irR <= irR;
      end
    end
  end

  assign ir            = irR;
  assign imm16         = irR[15:0];
  assign state         = stateR;
  assign pc_write      = ctlR[B_PC_WRITE];
  assign pc_write_cond = ctlR[B_PC_WRITE_COND];
  assign i_or_d        = ctlR[B_I_OR_D];
  assign mem_read      = ctlR[B_MEM_READ];
  assign mem_write     = ctlR[B_MEM_WRITE];
  assign ir_write      = ctlR[B_IR_WRITE];
  assign mem_to_reg    = ctlR[B_MEM_TO_REG];
  assign reg_dst       = ctlR[B_REG_DST];
  assign reg_write     = ctlR[B_REG_WRITE];
  assign alu_src_a     = ctlR[B_ALU_SRC_A];
  assign alu_src_b     = ctlR[7:6];
  assign alu_op        = ctlR[5:4];
  assign pc_source     = ctlR[3:2];
  assign illegal       = ctlR[B_ILLEGAL];
  assign instr_done    = ctlR[B_INSTR_DONE];

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle MIPS control unit. Expected state
// sequences and control words are written out by hand from the state table.
module tb_mips_multicycle_control;

  logic        clk;
  logic        reset;
  logic [31:0] mem_data;
  logic [31:0] ir;
  logic [15:0] imm16;
  logic [3:0]  state;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic        illegal, instr_done;

  int checks;
  int fails;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .mem_data(mem_data), .ir(ir), .imm16(imm16),
    .state(state), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal(illegal),
    .instr_done(instr_done)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed controls, ordered:
  // pw pwc iod mr mw irw m2r rdst rw asa asb[2] aop[2] psrc[2] ill done
  function automatic logic [17:0] obsCtl();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_source, illegal, instr_done};
  endfunction

  // Expected controls for each state, written directly from the state table.
  function automatic logic [17:0] expCtl(input int s);
    logic pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, ill, done;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, ill, done} = 12'd0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      0:  begin mr = 1'b1; irw = 1'b1; pw = 1'b1; asb = 2'b01; end
      1:  begin asb = 2'b11; end
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  begin mr = 1'b1; iod = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
      5:  begin mw = 1'b1; iod = 1'b1; done = 1'b1; end
      6:  begin asa = 1'b1; aop = 2'b10; end
      7:  begin rdst = 1'b1; rw = 1'b1; done = 1'b1; end
      8:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; done = 1'b1; end
      9:  begin pw = 1'b1; psrc = 2'b10; done = 1'b1; end
      10: begin asa = 1'b1; asb = 2'b10; end
      11: begin rw = 1'b1; done = 1'b1; end
      12: begin ill = 1'b1; end
      default: begin end
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill, done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then check the state and the full control word.
  task automatic step(input int expState);
    @(negedge clk);
    chk($sformatf("state_exp%0d", expState), {28'd0, state}, expState);
    chk($sformatf("ctl_in%0d", expState), {14'd0, obsCtl()}, {14'd0, expCtl(expState)});
  endtask

  initial begin
    checks = 0;
    fails = 0;
    reset = 1'b1;
    mem_data = 32'h8C22001A;

    // Reset: FETCH, IR cleared, FETCH decode on the outputs.
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_ir", ir, 32'd0);
    chk("reset_ctl", {14'd0, obsCtl()}, {14'd0, expCtl(0)});
    reset = 1'b0;

    // lw: 0,1,2,3,4,0
    step(1);
    chk("lw_ir", ir, 32'h8C22001A);
    chk("lw_imm16", {16'd0, imm16}, 32'h0000001A);
    step(2); step(3); step(4); step(0);

    // sw: 0,1,2,5,0
    mem_data = 32'hAC22FFFC;
    step(1);
    chk("sw_imm16", {16'd0, imm16}, 32'h0000FFFC);
    step(2); step(5); step(0);

    // R-type: 0,1,6,7,0
    mem_data = 32'h00432020;
    step(1);
    chk("r_ir", ir, 32'h00432020);
    step(6); step(7); step(0);

    // addi: 0,1,10,11,0
    mem_data = 32'h2001FFFF;
    step(1);
    chk("addi_imm16", {16'd0, imm16}, 32'h0000FFFF);
    step(10); step(11); step(0);

    // beq: 0,1,8,0
    mem_data = 32'h1022FFFE;
    step(1); step(8); step(0);

    // j: 0,1,9,0
    mem_data = 32'h08000004;
    step(1); step(9); step(0);

    // IR holds while not in FETCH even if memory data changes.
    mem_data = 32'hFC000000;
    step(1);
    mem_data = 32'h12345678;
    step(12);
    chk("trap_ir_hold", ir, 32'hFC000000);
    for (int i = 0; i < 10; i++) begin
      step(12);
    end
    chk("trap_illegal", {31'd0, illegal}, 32'd1);

    // Asynchronous reset between edges, from TRAP.
    #2;
    reset = 1'b1;
    #1;
    chk("async_state", {28'd0, state}, 32'd0);
    chk("async_ir", ir, 32'd0);
    chk("async_ctl", {14'd0, obsCtl()}, {14'd0, expCtl(0)});
    mem_data = 32'h08000004;
    @(negedge clk);
    chk("rst_hold_state", {28'd0, state}, 32'd0);
    chk("rst_hold_ir", ir, 32'd0);
    reset = 1'b0;

    // First edge after reset loads IR.
    step(1);
    chk("post_rst_ir", ir, 32'h08000004);
    step(9); step(0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
